// File: rtl/thermal_fan_ctrl_if.sv
// Purpose: groups the thermal manager's sensor/scheduler-facing signals into one bundle.
// Latency: none; this is wiring only.
// Backpressure: none; every signal is a level, sampled on each rising clock edge.
interface thermal_fan_ctrl_if #(
    parameter int TEMP_W = 7,
    parameter int FAN_W  = 3
);
    logic [TEMP_W-1:0] temperature;
    logic              req_in_use;
    logic              alarm_clr;
    logic              in_use;
    logic [FAN_W-1:0]  fan_speed;
    logic              throttle;
    logic              overtemp_alarm;

    // Environment side: scheduler and sensors drive the inputs and observe the outputs
    modport master (
        output temperature, req_in_use, alarm_clr,
        input  in_use, fan_speed, throttle, overtemp_alarm
    );

    // Controller side
    modport slave (
        input  temperature, req_in_use, alarm_clr,
        output in_use, fan_speed, throttle, overtemp_alarm
    );
endinterface

// File: rtl/thermal_fan_ctrl.sv
// Purpose: samples temperature periodically and drives a ramped, hysteretic fan level; gates compute grant (throttle/shutdown).
// Latency: grant is 1 cycle after req_in_use; state and target update 1 cycle after each sample tick.
// Backpressure: none; req_in_use is gated (duty-cycled or blocked), never stalled.
module thermal_fan_ctrl #(
    parameter int TEMP_W        = 7,
    parameter int FAN_W         = 3,
    parameter int SAMPLE_PERIOD = 16,
    parameter int RAMP_DELAY    = 8,
    parameter int T_LOW         = 50,
    parameter int T_HIGH        = 70,
    parameter int T_CRIT        = 90,
    parameter int HYST          = 4
) (
    input  logic              CLK,
    input  logic              RST,
    thermal_fan_ctrl_if.slave tf
);
    localparam int FAN_MAX = (2**FAN_W) - 1;
    localparam int SCNT_W  = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int RCNT_W  = $clog2(RAMP_DELAY + 1);
    localparam int TW1     = TEMP_W + 1;

    localparam logic [TEMP_W-1:0] T_LOW_V     = TEMP_W'(T_LOW);
    localparam logic [TEMP_W-1:0] T_HIGH_V    = TEMP_W'(T_HIGH);
    localparam logic [TEMP_W-1:0] T_CRIT_V    = TEMP_W'(T_CRIT);
    localparam logic [TEMP_W-1:0] T_EXIT_V    = TEMP_W'(T_HIGH - HYST);
    localparam logic [FAN_W-1:0]  FAN_MAX_V   = FAN_W'(FAN_MAX);
    localparam logic [SCNT_W-1:0] SAMPLE_LAST = SCNT_W'(SAMPLE_PERIOD - 1);
    localparam logic [RCNT_W-1:0] RAMP_FULL   = RCNT_W'(RAMP_DELAY);

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        THROTTLE = 2'd1,
        SHUTDOWN = 2'd2
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [SCNT_W-1:0] sample_cnt;
    logic              tick;
    logic              eval;
    logic              phase;
    logic [TEMP_W-1:0] temp_q;
    logic [FAN_W-1:0]  target;
    logic [FAN_W-1:0]  fan_q;
    logic [RCNT_W-1:0] ramp_cnt;
    logic              dec_pend;
    logic              in_use_q;
    logic              throttle_q;
    logic              alarm_q;

    logic [TW1-1:0]    excess;
    logic [TW1-1:0]    level;
    logic [FAN_W-1:0]  raw_target;
    logic [FAN_W-1:0]  cand_target;

    assign tick = (sample_cnt == SAMPLE_LAST);

    // Sample window: free-running counter, temperature capture and throttle duty phase
    always_ff @(posedge CLK) begin
        if (RST) begin
            sample_cnt <= '0;
            temp_q     <= '0;
            phase      <= 1'b0;
            eval       <= 1'b0;
        end else begin
            sample_cnt <= tick ? '0 : sample_cnt + 1'b1;
            eval       <= tick;
            if (tick) begin
                temp_q <= tf.temperature;
                phase  <= ~phase;
            end
        end
    end

    // Transition function: temperature thresholds only act on the cycle after a sample,
    // while a shutdown release request is honoured on any cycle
    always_comb begin
        next_state = state;
        case (state)
            NORMAL: begin
                if (eval) begin
                    if (temp_q >= T_CRIT_V)      next_state = SHUTDOWN;
                    else if (temp_q >= T_HIGH_V) next_state = THROTTLE;
                end
            end
            THROTTLE: begin
                if (eval) begin
                    if (temp_q >= T_CRIT_V)       next_state = SHUTDOWN;
                    else if (temp_q <= T_EXIT_V)  next_state = NORMAL;
                end
            end
            SHUTDOWN: begin
                if (tf.alarm_clr && (temp_q < T_LOW_V)) next_state = NORMAL;
            end
            default: next_state = NORMAL;
        endcase
    end

    // Fan target from the held sample: one level per 4 degrees above T_LOW, pinned to max when throttling
    always_comb begin
        excess     = {1'b0, temp_q} - TW1'(T_LOW);
        level      = (excess >> 2) + 1'b1;
        raw_target = '0;
        if (temp_q >= T_LOW_V) begin
            if (level > TW1'(FAN_MAX)) raw_target = FAN_MAX_V;
            else                       raw_target = level[FAN_W-1:0];
        end
        cand_target = (next_state != NORMAL) ? FAN_MAX_V : raw_target;
    end

    // FSM with registered grant and status flags, all following the next state
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= NORMAL;
            in_use_q   <= 1'b0;
            throttle_q <= 1'b0;
            alarm_q    <= 1'b0;
        end else begin
            state      <= next_state;
            throttle_q <= (next_state != NORMAL);
            alarm_q    <= (next_state == SHUTDOWN);
            case (next_state)
                NORMAL:   in_use_q <= tf.req_in_use;
                THROTTLE: in_use_q <= tf.req_in_use & phase;
                default:  in_use_q <= 1'b0;
            endcase
        end
    end

    // Target acceptance (decreases need two consecutive lower samples) and rate-limited fan ramp
    always_ff @(posedge CLK) begin
        if (RST) begin
            target   <= '0;
            dec_pend <= 1'b0;
            ramp_cnt <= '0;
            fan_q    <= '0;
        end else begin
            if (eval) begin
                if (cand_target < fan_q) begin
                    if (dec_pend) begin
                        target   <= cand_target;
                        dec_pend <= 1'b0;
                    end else begin
                        dec_pend <= 1'b1;
                    end
                end else begin
                    target   <= cand_target;
                    dec_pend <= 1'b0;
                end
            end
            // The step compares against the target held before this edge, so a freshly
            // accepted target only steers steps from the following cycle onwards
            if ((ramp_cnt == RAMP_FULL) && (fan_q != target)) begin
                fan_q    <= (target > fan_q) ? fan_q + 1'b1 : fan_q - 1'b1;
                ramp_cnt <= '0;
            end else if (ramp_cnt != RAMP_FULL) begin
                ramp_cnt <= ramp_cnt + 1'b1;
            end
        end
    end

    assign tf.in_use         = in_use_q;
    assign tf.fan_speed      = fan_q;
    assign tf.throttle       = throttle_q;
    assign tf.overtemp_alarm = alarm_q;
endmodule

// File: tb/tb_thermal_fan_ctrl.sv
// Purpose: self-checking bench for thermal_fan_ctrl: directed vector table, short hand sequences, randomized run.
// Latency: compares outputs 1 ns after every rising edge against a time-indexed reference model.
// Backpressure: not applicable.
module tb_thermal_fan_ctrl;
    localparam int TEMP_W  = 7;
    localparam int FAN_W   = 3;
    localparam int SP      = 16;
    localparam int RD      = 8;
    localparam int T_LOW   = 50;
    localparam int T_HIGH  = 70;
    localparam int T_CRIT  = 90;
    localparam int HYST    = 4;
    localparam int FAN_MAX = 7;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    thermal_fan_ctrl_if #(.TEMP_W(TEMP_W), .FAN_W(FAN_W)) tf ();

    thermal_fan_ctrl #(
        .TEMP_W(TEMP_W), .FAN_W(FAN_W), .SAMPLE_PERIOD(SP), .RAMP_DELAY(RD),
        .T_LOW(T_LOW), .T_HIGH(T_HIGH), .T_CRIT(T_CRIT), .HYST(HYST)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .tf (tf.slave)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: everything is derived from k, the number of edges since reset,
    // and from the time of the last fan step, rather than from explicit counters.
    int m_k, m_last, m_state, m_tq, m_target, m_fan, m_dec, m_in, m_thr, m_al;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s at t=%0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    function automatic int raw_level(input int t);
        int v;
        if (t < T_LOW) return 0;
        v = (t - T_LOW) / 4 + 1;
        return (v > FAN_MAX) ? FAN_MAX : v;
    endfunction

    task automatic model_edge();
        int ns, old_phase, old_target, cand;
        bit is_eval;
        if (RST) begin
            m_k = 0; m_last = 0; m_state = 0; m_tq = 0; m_target = 0;
            m_fan = 0; m_dec = 0; m_in = 0; m_thr = 0; m_al = 0;
            return;
        end
        m_k++;
        old_phase  = ((m_k - 1) / SP) % 2;
        old_target = m_target;
        is_eval    = (m_k > SP) && (m_k % SP == 1);
        ns         = m_state;
        if (is_eval) begin
            if (m_state == 0) begin
                if (m_tq >= T_CRIT) ns = 2;
                else if (m_tq >= T_HIGH) ns = 1;
            end else if (m_state == 1) begin
                if (m_tq >= T_CRIT) ns = 2;
                else if (m_tq <= T_HIGH - HYST) ns = 0;
            end
        end
        if (m_state == 2 && tf.alarm_clr && m_tq < T_LOW) ns = 0;
        m_thr = (ns != 0);
        m_al  = (ns == 2);
        m_in  = (ns == 0) ? int'(tf.req_in_use) : (ns == 1) ? (int'(tf.req_in_use) & old_phase) : 0;
        if (is_eval) begin
            cand = (ns != 0) ? FAN_MAX : raw_level(m_tq);
            if (cand < m_fan) begin
                if (m_dec != 0) begin m_target = cand; m_dec = 0; end
                else m_dec = 1;
            end else begin
                m_target = cand; m_dec = 0;
            end
        end
        if ((m_k - m_last >= RD + 1) && (m_fan != old_target)) begin
            m_fan  = m_fan + ((old_target > m_fan) ? 1 : -1);
            m_last = m_k;
        end
        if (m_k % SP == 0) m_tq = int'(tf.temperature);
        m_state = ns;
    endtask

    function automatic int pack_dut();
        return int'(tf.fan_speed) * 8 + int'(tf.in_use) * 4 + int'(tf.throttle) * 2 + int'(tf.overtemp_alarm);
    endfunction

    function automatic int pack_model();
        return m_fan * 8 + m_in * 4 + m_thr * 2 + m_al;
    endfunction

    task automatic cycle();
        @(posedge CLK);
        model_edge();
        #1;
        check("model", pack_dut(), pack_model());
    endtask

    task automatic drive(input bit rst, input int temp, input bit req, input bit clr);
        RST               = rst;
        tf.temperature    = TEMP_W'(temp);
        tf.req_in_use     = req;
        tf.alarm_clr      = clr;
    endtask

    typedef struct {
        bit rst;
        int temp;
        bit req;
        bit clr;
        int ncyc;
        int fan;
        bit in_use;
        bit thr;
        bit al;
    } vec_t;

    vec_t vecs[$];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hold;
        int tcur;
        int picks[16];

        drive(1'b1, 30, 1'b1, 1'b0);

        //             rst temp req clr  n    fan in thr al
        vecs.push_back('{1, 30, 1, 0,   1,   0, 0, 0, 0}); // reset
        vecs.push_back('{0, 30, 1, 0, 200,   0, 1, 0, 0}); // cool, k=200
        vecs.push_back('{0, 62, 1, 0,  12,   1, 1, 0, 0}); // first step at k=210
        vecs.push_back('{0, 62, 1, 0,  28,   4, 1, 0, 0}); // steps 219,228,237
        vecs.push_back('{0, 62, 1, 0,  40,   4, 1, 0, 0}); // holds at 4
        vecs.push_back('{0, 45, 1, 0,  16,   4, 1, 0, 0}); // one low sample
        vecs.push_back('{0, 62, 1, 0,  16,   4, 1, 0, 0}); // pending decrease cleared
        vecs.push_back('{0, 45, 1, 0,  32,   3, 1, 0, 0}); // two low samples, step at 338
        vecs.push_back('{0, 45, 1, 0,  24,   0, 1, 0, 0}); // k=368
        vecs.push_back('{0, 72, 1, 0,  20,   1, 0, 1, 0}); // THROTTLE, phase 0
        vecs.push_back('{0, 72, 1, 0,  60,   7, 1, 1, 0}); // k=448, phase 1
        vecs.push_back('{0, 72, 1, 0,  16,   7, 0, 1, 0}); // k=464, phase 0
        vecs.push_back('{0, 67, 1, 0,  32,   7, 0, 1, 0}); // 67 keeps THROTTLE
        vecs.push_back('{0, 66, 1, 0,  18,   7, 1, 0, 0}); // 66 -> NORMAL, fan held
        vecs.push_back('{0, 66, 0, 0,   2,   7, 0, 0, 0}); // grant follows req
        vecs.push_back('{0, 95, 1, 0,  16,   7, 0, 1, 1}); // SHUTDOWN
        vecs.push_back('{0, 55, 1, 0,  16,   7, 0, 1, 1});
        vecs.push_back('{0, 55, 1, 1,   1,   7, 0, 1, 1}); // clr at 55 ignored
        vecs.push_back('{0, 40, 1, 0,  16,   7, 0, 1, 1}); // not remembered
        vecs.push_back('{0, 40, 1, 1,   1,   7, 1, 0, 0}); // clr at 40 releases
        vecs.push_back('{0, 40, 1, 0,   2,   7, 1, 0, 0});
        vecs.push_back('{0, 95, 1, 0,  12,   7, 0, 1, 1}); // SHUTDOWN again, fan 7
        vecs.push_back('{1, 95, 1, 0,   1,   0, 0, 0, 0}); // reset mid-shutdown
        vecs.push_back('{0, 95, 1, 0,  16,   0, 1, 0, 0}); // first sample at k=16
        vecs.push_back('{0, 95, 1, 0,   1,   0, 0, 1, 1}); // evaluated at k=17
        vecs.push_back('{0, 95, 1, 0,   9,   1, 0, 1, 1}); // step at 18
        vecs.push_back('{0, 95, 1, 0,   1,   2, 0, 1, 1}); // next step exactly 9 later

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].temp, vecs[i].req, vecs[i].clr);
            for (int c = 0; c < vecs[i].ncyc; c++) cycle();
            check($sformatf("vec%0d.fan", i),    int'(tf.fan_speed),      vecs[i].fan);
            check($sformatf("vec%0d.in_use", i), int'(tf.in_use),         int'(vecs[i].in_use));
            check($sformatf("vec%0d.thr", i),    int'(tf.throttle),       int'(vecs[i].thr));
            check($sformatf("vec%0d.alarm", i),  int'(tf.overtemp_alarm), int'(vecs[i].al));
        end

        // Grant latency: a one-cycle request appears exactly one edge later for one cycle
        drive(1'b1, 30, 1'b0, 1'b0);
        cycle();
        drive(1'b0, 30, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) cycle();
        check("lat_idle", int'(tf.in_use), 0);
        tf.req_in_use = 1'b1;
        #2;
        check("lat_pre_edge", int'(tf.in_use), 0);
        cycle();
        check("lat_rise", int'(tf.in_use), 1);
        tf.req_in_use = 1'b0;
        cycle();
        check("lat_fall", int'(tf.in_use), 0);

        // Randomized run around the thresholds with occasional release pulses and resets
        picks = '{0, 30, 49, 50, 53, 54, 62, 66, 67, 69, 70, 71, 89, 90, 95, 127};
        hold  = 0;
        tcur  = 30;
        for (int c = 0; c < 4000; c++) begin
            if (hold == 0) begin
                tcur = ($urandom_range(3, 0) == 0) ? int'($urandom_range(127, 0)) : picks[$urandom_range(15, 0)];
                hold = $urandom_range(40, 1);
            end
            hold--;
            drive($urandom_range(1999, 0) == 0, tcur, $urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
